// File: rtl/expr_paren_checker.sv
// -----------------------------------------------------------------------------
// expr_paren_checker
//
// Streaming recogniser for infix integer expressions. One ASCII character is
// consumed on each rising clk edge while in_valid is high. The grammar is:
//   expr := term (op term)* ; term := number | '(' expr ')' ;
//   number := digit{1..MAX_DIGITS}
//
// The operator set is configurable. Operands may have several digits, and a
// leading zero can optionally be banned. Parentheses may nest up to MAX_DEPTH.
// Any syntax or limit violation latches err until clr is asserted.
//
// Ports
//   clk       in   1        clock, rising edge
//   clr       in   1        asynchronous, active-high reset
//   in        in   8        ASCII character
//   in_valid  in   1        in is consumed only while in_valid=1
//   out       out  1        characters consumed so far form a complete expression
//   err       out  1        sticky syntax/limit error
//   depth     out  DEPTH_W  current open-paren nesting depth
//   operands  out  CNT_W    numbers started so far (saturating)
// -----------------------------------------------------------------------------
module expr_paren_checker #(
  parameter int       MAX_DIGITS   = 4,        // 0 = unlimited
  parameter int       MAX_DEPTH    = 7,        // 1..(2**DEPTH_W-1)
  parameter int       DEPTH_W      = 3,
  parameter bit [3:0] OP_MASK      = 4'b0011,  // bit0 '+', bit1 '*', bit2 '-', bit3 '/'
  parameter bit       NO_LEAD_ZERO = 1'b1,
  parameter int       CNT_W        = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   operands
);

  // The digit counter only has to reach MAX_DIGITS. When there is no digit
  // limit it is never used, so it is kept at a single bit.
  localparam int DCNT_W = (MAX_DIGITS == 0) ? 1 : $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    S_EXP = 2'd0,  // expecting a term
    S_NUM = 2'd1,  // inside a number
    S_CLS = 2'd2,  // just after ')'
    S_ERR = 2'd3   // absorbing error state
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                lead0_q, lead0_d;
  logic [CNT_W-1:0]    operands_d;

  // Character classes. An operator whose mask bit is clear falls into "other".
  logic is_digit, is_op, is_lpar, is_rpar;
  logic digits_full, depth_full, depth_empty;

  always_comb begin
    is_digit = (in >= "0") && (in <= "9");
    is_op    = (OP_MASK[0] && in == "+") || (OP_MASK[1] && in == "*") ||
               (OP_MASK[2] && in == "-") || (OP_MASK[3] && in == "/");
    is_lpar  = (in == "(");
    is_rpar  = (in == ")");
  end

  assign digits_full = (MAX_DIGITS != 0) && (dcnt_q == DCNT_W'(MAX_DIGITS));
  assign depth_full  = (depth == DEPTH_W'(MAX_DEPTH));
  assign depth_empty = (depth == '0);

  // NOTE: always_ff holds only non-blocking assignments, so every register
  // samples the values from before the edge, whatever order the lines are in.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_EXP;
      depth    <= '0;
      dcnt_q   <= '0;
      lead0_q  <= 1'b0;
      operands <= '0;
    end else begin
      state_q  <= state_d;
      depth    <= depth_d;
      dcnt_q   <= dcnt_d;
      lead0_q  <= lead0_d;
      operands <= operands_d;
    end
  end

  // NOTE: each signal gets a hold value before the case statement. Any branch
  // that leaves a signal unassigned then keeps it, and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth;
    dcnt_d     = dcnt_q;
    lead0_d    = lead0_q;
    operands_d = operands;

    if (in_valid) begin
      unique case (state_q)
        S_EXP: begin
          if (is_digit) begin
            state_d = S_NUM;
            dcnt_d  = (MAX_DIGITS != 0) ? DCNT_W'(1) : '0;
            lead0_d = (in == "0");
            if (operands != '1) operands_d = operands + CNT_W'(1);
          end else if (is_lpar) begin
            if (depth_full) state_d = S_ERR;
            else            depth_d = depth + DEPTH_W'(1);
          end else begin
            state_d = S_ERR;
          end
        end

        S_NUM: begin
          if (is_digit) begin
            if (digits_full || (NO_LEAD_ZERO && lead0_q)) state_d = S_ERR;
            else if (MAX_DIGITS != 0)                    dcnt_d  = dcnt_q + DCNT_W'(1);
          end else if (is_op) begin
            state_d = S_EXP;
          end else if (is_rpar) begin
            if (depth_empty) state_d = S_ERR;
            else begin
              depth_d = depth - DEPTH_W'(1);
              state_d = S_CLS;
            end
          end else begin
            state_d = S_ERR;
          end
        end

        S_CLS: begin
          if (is_op) begin
            state_d = S_EXP;
          end else if (is_rpar) begin
            if (depth_empty) state_d = S_ERR;
            else             depth_d = depth - DEPTH_W'(1);
          end else begin
            state_d = S_ERR;
          end
        end

        default: ;  // S_ERR: everything frozen until clr
      endcase
    end
  end

  // Both flags come straight from registers, so they change only on a clock
  // edge or on clr.
  assign out = ((state_q == S_NUM) || (state_q == S_CLS)) && depth_empty;
  assign err = (state_q == S_ERR);

endmodule

// File: tb/tb_expr_paren_checker.sv
// -----------------------------------------------------------------------------
// tb_expr_paren_checker
//
// Directed bench for expr_paren_checker.
//   dut   : default parameters (ops '+' and '*' only)
//   dut_b : all four operators enabled
// Both instances receive the same character stream. Outputs are sampled 1 ns
// after the clock edge that consumed a character.
// -----------------------------------------------------------------------------
module tb_expr_paren_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] in  = 8'h00;
  logic       in_valid = 1'b0;

  logic       out, err;
  logic [2:0] depth;
  logic [7:0] operands;
  logic       out_b, err_b;
  logic [2:0] depth_b;
  logic [7:0] operands_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  expr_paren_checker dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .err      (err),
    .depth    (depth),
    .operands (operands)
  );

  expr_paren_checker #(.OP_MASK(4'b1111)) dut_b (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .out      (out_b),
    .err      (err_b),
    .depth    (depth_b),
    .operands (operands_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Consume one character. Returns 1 ns after the consuming edge.
  task automatic send(input byte c);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Send a string and check out after every character against a '0'/'1' map.
  task automatic send_chk(input string s, input string out_map, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      check($sformatf("%s[%0d]", tag, i), 32'(out), (out_map[i] == "1") ? 32'd1 : 32'd0);
    end
  endtask

  // Pulse clr away from any clock edge.
  task automatic do_clr();
    clr = 1'b1;
    #3;
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    check("rst_out", 32'(out), 0);
    check("rst_err", 32'(err), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_operands", 32'(operands), 0);

    // T1: multi-digit operands and one paren level
    send_chk("12+3*(45)", "110100001", "t1_out");
    check("t1_err", 32'(err), 0);
    check("t1_depth", 32'(depth), 0);
    check("t1_operands", 32'(operands), 3);

    // T2: nesting, then one ')' too many
    do_clr();
    send_str("((7");
    check("t2_depth2", 32'(depth), 2);
    check("t2_out_open", 32'(out), 0);
    check("t2_ops", 32'(operands), 1);
    send_str("))");
    check("t2_depth0", 32'(depth), 0);
    check("t2_out_closed", 32'(out), 1);
    send(")");
    check("t2_err", 32'(err), 1);
    check("t2_out_err", 32'(out), 0);
    check("t2_depth_frozen", 32'(depth), 0);
    send_str("5+(");
    check("t2_err_sticky", 32'(err), 1);
    check("t2_ops_frozen", 32'(operands), 1);
    check("t2_depth_still", 32'(depth), 0);

    // T3: digit limit and leading-zero ban
    do_clr();
    send_str("1234");
    check("t3_4dig_out", 32'(out), 1);
    check("t3_4dig_err", 32'(err), 0);
    send("5");
    check("t3_5dig_err", 32'(err), 1);
    do_clr();
    send("0");
    check("t3_lone0_out", 32'(out), 1);
    send("7");
    check("t3_lead0_err", 32'(err), 1);
    do_clr();
    send_chk("0+0", "101", "t3_0p0");
    check("t3_0p0_err", 32'(err), 0);
    do_clr();
    send_str("10+9999*1");
    check("t3_mixed_out", 32'(out), 1);
    check("t3_mixed_err", 32'(err), 0);

    // T4: masked-off operator versus a full operator set
    do_clr();
    send_str("3-1");
    check("t4_minus_err", 32'(err), 1);
    check("t4_b_minus_ok", 32'(err_b), 0);
    do_clr();
    send_str("8/2-1");
    check("t4_b_out", 32'(out_b), 1);
    check("t4_b_err", 32'(err_b), 0);
    check("t4_b_operands", 32'(operands_b), 3);
    check("t4_a_div_err", 32'(err), 1);

    // T5: depth limit and an empty paren pair
    do_clr();
    for (int i = 0; i < 7; i++) send("(");
    check("t5_depth7", 32'(depth), 7);
    check("t5_err0", 32'(err), 0);
    send("(");
    check("t5_depth_over", 32'(err), 1);
    check("t5_depth_frozen", 32'(depth), 7);
    do_clr();
    send("(");
    check("t5_lpar_err", 32'(err), 0);
    send(")");
    check("t5_empty_err", 32'(err), 1);

    // T6: in_valid gating and a mid-stream clr
    do_clr();
    in = "5";
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_hold_out", 32'(out), 0);
    check("t6_hold_ops", 32'(operands), 0);
    send("5");
    check("t6_5_out", 32'(out), 1);
    in = "+";
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_hold_plus", 32'(out), 1);
    send("+");
    check("t6_plus_out", 32'(out), 0);
    clr = 1'b1;
    #2;
    check("t6_clr_out", 32'(out), 0);
    check("t6_clr_err", 32'(err), 0);
    check("t6_clr_depth", 32'(depth), 0);
    check("t6_clr_ops", 32'(operands), 0);
    #1;
    clr = 1'b0;
    send("9");
    check("t6_9_out", 32'(out), 1);
    check("t6_9_ops", 32'(operands), 1);

    // Operand counter saturation: 301 numbers, counter stops at 255
    do_clr();
    for (int i = 0; i < 300; i++) send_str("1+");
    send("1");
    check("sat_operands", 32'(operands), 255);
    check("sat_out", 32'(out), 1);
    check("sat_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
